// File: rtl/motor_pwm_rampa_if.sv
// Signal bundle between the ramp-start FSM (master) and the PWM ramp stage (slave).
// fsm_state is a debug view of the slave's internal state.
interface motor_pwm_rampa_if;
  // Level-only link: sel_* are plain levels sampled every clk, with no valid/ready.
  // Outputs are registered levels that are meaningful on every cycle.
  logic       sel_30;
  logic       sel_50;
  logic       sel_100;
  logic       pwm_out;
  logic [6:0] duty_actual;
  logic       at_target;
  logic       fault;
  logic [1:0] fsm_state;

  modport master (
    output sel_30, sel_50, sel_100,
    input  pwm_out, duty_actual, at_target, fault, fsm_state
  );

  modport slave (
    input  sel_30, sel_50, sel_100,
    output pwm_out, duty_actual, at_target, fault, fsm_state
  );
endinterface

// File: rtl/motor_pwm_rampa.sv
// PWM motor drive whose duty slews in STEP-% increments toward the one-hot requested level.
// Build option: define PWM_SOFT_STOP_EN to ramp down to 0 instead of stopping hard.
module motor_pwm_rampa #(
    parameter int PRESCALE     = 4,
    parameter int RAMP_PERIODS = 8,
    parameter int STEP         = 1
) (
    input  logic               clk,
    input  logic               reset,
    motor_pwm_rampa_if.slave   bus
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_RAMP_UP   = 2'd1;
    localparam logic [1:0] S_RAMP_DOWN = 2'd2;
    localparam logic [1:0] S_HOLD      = 2'd3;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [7:0] STEP8 = 8'(STEP);
    localparam logic [6:0] STEP7 = 7'(STEP);

    logic [2:0]    sel_r;
    logic          multi_hot;
    logic [6:0]    target;
    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [6:0]    pwm_cnt;
    logic          boundary;
    logic [RW-1:0] ramp_cnt, ramp_n;
    logic          step_due;
    logic [1:0]    state, state_n, settle;
    logic [6:0]    duty, duty_n;
    logic [7:0]    up_sum, dn_floor;
    logic [6:0]    up_val, dn_val;
    logic          hard_stop;
    logic          pwm_r, at_target_r, fault_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sel_r <= 3'b000;
        else       sel_r <= {bus.sel_100, bus.sel_50, bus.sel_30};
    end

    assign multi_hot = (sel_r[0] & sel_r[1]) | (sel_r[0] & sel_r[2]) | (sel_r[1] & sel_r[2]);

    always_comb begin
        target = 7'd0;
        if (!multi_hot) begin
            if (sel_r[2])      target = 7'd100;
            else if (sel_r[1]) target = 7'd50;
            else if (sel_r[0]) target = 7'd30;
        end
    end

    assign tick = (pre_cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + PW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     pwm_cnt <= 7'd0;
        else if (tick) pwm_cnt <= (pwm_cnt == 7'd99) ? 7'd0 : pwm_cnt + 7'd1;
    end

    assign boundary = tick && (pwm_cnt == 7'd99);
    assign step_due = boundary && (ramp_cnt == RW'(RAMP_PERIODS - 1));

    // 8-bit sums so neither direction can wrap; both results clamp onto the target.
    assign up_sum   = {1'b0, duty} + STEP8;
    assign up_val   = (up_sum >= {1'b0, target}) ? target : up_sum[6:0];
    assign dn_floor = {1'b0, target} + STEP8;
    assign dn_val   = ({1'b0, duty} <= dn_floor) ? target : duty - STEP7;
    assign settle   = (target == 7'd0) ? S_IDLE : S_HOLD;

`ifdef PWM_SOFT_STOP_EN
    assign hard_stop = 1'b0;
`else
    assign hard_stop = (target == 7'd0);
`endif

    always_comb begin
        state_n = state;
        duty_n  = duty;
        ramp_n  = ramp_cnt;
        if (multi_hot) begin
            // Illegal request: drop the drive at once rather than wait for a boundary.
            state_n = S_IDLE;
            duty_n  = 7'd0;
            ramp_n  = '0;
        end else if (boundary) begin
            if (state != S_IDLE)
                ramp_n = (ramp_cnt == RW'(RAMP_PERIODS - 1)) ? '0 : ramp_cnt + RW'(1);
            case (state)
                S_IDLE: begin
                    duty_n = 7'd0;
                    if (target != 7'd0) state_n = S_RAMP_UP;
                end
                S_RAMP_UP: begin
                    if (target < duty)       state_n = S_RAMP_DOWN;
                    else if (target == duty) state_n = settle;
                    else if (step_due) begin
                        duty_n = up_val;
                        if (up_val == target) state_n = settle;
                    end
                end
                S_RAMP_DOWN: begin
                    if (target > duty)       state_n = S_RAMP_UP;
                    else if (target == duty) state_n = settle;
                    else if (step_due) begin
                        duty_n = dn_val;
                        if (dn_val == target) state_n = settle;
                    end
                end
                default: begin
                    if (target > duty)      state_n = S_RAMP_UP;
                    else if (target < duty) state_n = S_RAMP_DOWN;
                end
            endcase
            if (hard_stop) begin
                state_n = S_IDLE;
                duty_n  = 7'd0;
            end
            if (state_n == S_IDLE) ramp_n = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            duty     <= 7'd0;
            ramp_cnt <= '0;
        end else begin
            state    <= state_n;
            duty     <= duty_n;
            ramp_cnt <= ramp_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_r       <= 1'b0;
            at_target_r <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            pwm_r       <= (pwm_cnt < duty);
            at_target_r <= (duty == target) && !fault_r;
            fault_r     <= multi_hot;
        end
    end

    assign bus.pwm_out     = pwm_r;
    assign bus.duty_actual = duty;
    assign bus.at_target   = at_target_r;
    assign bus.fault       = fault_r;
    assign bus.fsm_state   = state;

endmodule

// File: tb/tb_motor_pwm_rampa.sv
// Directed bench for motor_pwm_rampa: table of hold levels plus fault, stop and reset sequences.
// Instance a uses STEP=5, instance b uses STEP=7 (PRESCALE=1, RAMP_PERIODS=2 for both).
module tb_motor_pwm_rampa;

  localparam int STEP_CLKS = 200;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [6:0] exp_q[$];

  typedef struct {
    logic [2:0] sel;
    int         dest;
    int         high;
  } vec_t;

  vec_t vecs[3];

  motor_pwm_rampa_if ifa ();
  motor_pwm_rampa_if ifb ();

  motor_pwm_rampa #(.PRESCALE(1), .RAMP_PERIODS(2), .STEP(5)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  motor_pwm_rampa #(.PRESCALE(1), .RAMP_PERIODS(2), .STEP(7)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] duty_of(input bit b);
    return b ? ifb.duty_actual : ifa.duty_actual;
  endfunction

  // drivers
  task automatic set_sel(input bit b, input logic [2:0] s);
    @(negedge clk);
    if (b) begin
      ifb.sel_100 = s[2]; ifb.sel_50 = s[1]; ifb.sel_30 = s[0];
    end else begin
      ifa.sel_100 = s[2]; ifa.sel_50 = s[1]; ifa.sel_30 = s[0];
    end
  endtask

  task automatic wait_change(input bit b, input int budget, output int val, output int dt);
    int start;
    logic [6:0] prev;
    start = cyc;
    prev  = duty_of(b);
    val   = prev;
    dt    = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (duty_of(b) != prev) begin
        val = duty_of(b);
        dt  = cyc - start;
        return;
      end
    end
  endtask

  // scoreboard: expected slew sequence, each step compared in order and spaced STEP_CLKS apart
  task automatic run_ramp(input bit b, input int from, input int to, input int step, input string name);
    int v, val, dt, last, k;
    v = from;
    while (v != to) begin
      if (to > v) v = (v + step > to) ? to : v + step;
      else        v = (v - step < to) ? to : v - step;
      exp_q.push_back(7'(v));
    end
    k = 0;
    last = 0;
    while (exp_q.size() > 0) begin
      logic [6:0] e;
      e = exp_q.pop_front();
      wait_change(b, 400, val, dt);
      if (dt < 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s_timeout: got duty %0d expected %0d", name, val, e);
        exp_q.delete();
        return;
      end
      check({name, "_step"}, val, int'(e));
      if (k > 0) check({name, "_interval"}, cyc - last, STEP_CLKS);
      last = cyc;
      k++;
    end
  endtask

  task automatic count_pwm(input int dest, input string name);
    int high;
    high = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifa.pwm_out) high++;
    end
    check(name, high, dest);
  endtask

  initial begin
    int cur, val, dt;
    ifa.sel_30 = 1'b0; ifa.sel_50 = 1'b0; ifa.sel_100 = 1'b0;
    ifb.sel_30 = 1'b0; ifb.sel_50 = 1'b0; ifb.sel_100 = 1'b0;
    vecs[0] = '{sel: 3'b001, dest: 30,  high: 30};
    vecs[1] = '{sel: 3'b100, dest: 100, high: 100};
    vecs[2] = '{sel: 3'b010, dest: 50,  high: 50};

    #2 reset = 1'b1;
    #1;
    check("reset_pwm",   ifa.pwm_out, 0);
    check("reset_duty",  ifa.duty_actual, 0);
    check("reset_at",    ifa.at_target, 0);
    check("reset_fault", ifa.fault, 0);
    check("reset_state", ifa.fsm_state, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_duty", ifa.duty_actual, 0);
    check("idle_at",   ifa.at_target, 1);

    // table: slew to each level, then hold
    cur = 0;
    for (int i = 0; i < 3; i++) begin
      set_sel(1'b0, vecs[i].sel);
      run_ramp(1'b0, cur, vecs[i].dest, 5, $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_state", i), ifa.fsm_state, 3);
      check($sformatf("vec%0d_at", i),    ifa.at_target, 1);
      check($sformatf("vec%0d_duty", i),  ifa.duty_actual, vecs[i].dest);
      count_pwm(vecs[i].high, $sformatf("vec%0d_pwm_high", i));
      cur = vecs[i].dest;
    end

    // multi-hot request at 50: fault and duty 0 two clks after the input edge
    set_sel(1'b0, 3'b101);
    @(negedge clk);
    check("fault_clk1", ifa.fault, 0);
    check("fault_duty_clk1", ifa.duty_actual, 50);
    @(negedge clk);
    check("fault_clk2", ifa.fault, 1);
    check("fault_duty_clk2", ifa.duty_actual, 0);
    check("fault_state", ifa.fsm_state, 0);
    @(negedge clk);
    check("fault_at", ifa.at_target, 0);
    set_sel(1'b0, 3'b010);
    repeat (2) @(negedge clk);
    check("fault_clear", ifa.fault, 0);
    run_ramp(1'b0, 0, 50, 5, "fault_recover");
    repeat (2) @(negedge clk);
    check("fault_recover_state", ifa.fsm_state, 3);

    // drop all requests at 50
    set_sel(1'b0, 3'b000);
`ifdef PWM_SOFT_STOP_EN
    run_ramp(1'b0, 50, 0, 5, "soft_stop");
`else
    wait_change(1'b0, 400, val, dt);
    check("hard_stop_duty", val, 0);
    check("hard_stop_latency_ok", int'(dt >= 1 && dt <= 102), 1);
`endif
    repeat (2) @(negedge clk);
    check("stop_state", ifa.fsm_state, 0);
    check("stop_duty",  ifa.duty_actual, 0);

    // STEP=7 clamp on the last step
    set_sel(1'b1, 3'b001);
    run_ramp(1'b1, 0, 30, 7, "b_to30");
    set_sel(1'b1, 3'b010);
    run_ramp(1'b1, 30, 50, 7, "b_to50");
    repeat (2) @(negedge clk);
    check("b_state", ifb.fsm_state, 3);
    check("b_at",    ifb.at_target, 1);

    // reset in the middle of a ramp at duty 40
    set_sel(1'b0, 3'b100);
    run_ramp(1'b0, 0, 40, 5, "pre_reset");
    #3 reset = 1'b1;
    #1;
    check("midreset_pwm",   ifa.pwm_out, 0);
    check("midreset_duty",  ifa.duty_actual, 0);
    check("midreset_at",    ifa.at_target, 0);
    check("midreset_fault", ifa.fault, 0);
    check("midreset_state", ifa.fsm_state, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_ramp(1'b0, 0, 10, 5, "post_reset");

    // final report
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
